// File: rtl/spi_mem_pkg.sv
// Shared definitions for the SPI memory target: command opcodes and one-hot FSM states.
package spi_mem_pkg;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_WREN  = 8'h06;
    localparam logic [7:0] CMD_RDSR  = 8'h05;

    typedef enum logic [5:0] {
        ST_IDLE    = 6'b000001,
        ST_CMD     = 6'b000010,
        ST_ADDR    = 6'b000100,
        ST_DATA_RD = 6'b001000,
        ST_DATA_WR = 6'b010000,
        ST_IGNORE  = 6'b100000
    } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer for an asynchronous SPI clock with single-cycle rise/fall pulses
// generated from the synchronized level.
module spi_sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            prev  <= chain[STAGES-1];
        end
    end

    assign rise = chain[STAGES-1] & ~prev;
    assign fall = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/spi_mem_target.sv
// SPI mode-0 memory target: command byte, ADDR_BYTES of address, then sequential read/write data.
// Optional WREN latch and RDSR status command enabled by defining SPI_MEM_TARGET_WREN_EN.
module spi_mem_target
    import spi_mem_pkg::*;
#(
    parameter int unsigned ADDR_BYTES  = 3,
    parameter int unsigned MEM_BYTES   = 256,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sclk,
    input  logic                         cs_n,
    input  logic                         mosi,
    output logic                         miso,
    output logic                         miso_oe,
    output logic                         busy,
    input  logic                         host_we,
    input  logic [$clog2(MEM_BYTES)-1:0] host_addr,
    input  logic [7:0]                   host_wdata,
    output logic [7:0]                   host_rdata
);

    localparam int unsigned AW        = $clog2(MEM_BYTES);
    localparam int unsigned ADDR_BITS = 8 * ADDR_BYTES;
    localparam int unsigned CW        = $clog2(ADDR_BITS);
    localparam logic [CW-1:0] BYTE_LAST = CW'(7);
    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_BITS - 1);

    logic [7:0]             mem [MEM_BYTES];

    logic [SYNC_STAGES-1:0] cs_chain;
    logic [SYNC_STAGES-1:0] mosi_chain;
    logic                   cs_sync;
    logic                   mosi_sync;
    logic                   sclk_rise;
    logic                   sclk_fall;

    state_t                 state;
    logic [CW-1:0]          bit_cnt;
    logic [7:0]             shift_in;
    logic [7:0]             tx_shift;
    logic [AW-1:0]          addr;
    logic                   is_write;
    logic                   preload;
    logic                   armed;
    logic                   wr_step;
    logic [7:0]             wr_data;
    logic                   wr_commit;
    logic [7:0]             rx_byte;
    logic [7:0]             next_tx;

`ifdef SPI_MEM_TARGET_WREN_EN
    logic                   wel;
    logic                   wr_keep;
    logic                   saw_write;
    logic                   status_rd;
`endif

    spi_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    // cs_n resets to "selected" so a frame still running across reset cannot look like
    // a fresh select; only a genuinely observed high arms the FSM again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_chain   <= '0;
            mosi_chain <= '0;
        end else begin
            cs_chain   <= {cs_chain[SYNC_STAGES-2:0], cs_n};
            mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], mosi};
        end
    end

    assign cs_sync   = cs_chain[SYNC_STAGES-1];
    assign mosi_sync = mosi_chain[SYNC_STAGES-1];
    assign rx_byte   = {shift_in[6:0], mosi_sync};

`ifdef SPI_MEM_TARGET_WREN_EN
    assign wr_commit = wr_step & wr_keep;
    assign next_tx   = status_rd ? {6'b0, wel, 1'b0} : mem[addr];
`else
    assign wr_commit = wr_step;
    assign next_tx   = mem[addr];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shift_in  <= '0;
            tx_shift  <= '0;
            addr      <= '0;
            is_write  <= 1'b0;
            preload   <= 1'b0;
            armed     <= 1'b0;
            wr_step   <= 1'b0;
            wr_data   <= '0;
            miso      <= 1'b0;
            miso_oe   <= 1'b0;
            busy      <= 1'b0;
`ifdef SPI_MEM_TARGET_WREN_EN
            wel       <= 1'b0;
            wr_keep   <= 1'b0;
            saw_write <= 1'b0;
            status_rd <= 1'b0;
`endif
        end else begin
            armed   <= armed | cs_sync;
            wr_step <= 1'b0;
            if (wr_step) begin
                addr <= addr + 1'b1;
            end

            if (state != ST_IDLE && cs_sync) begin
                state    <= ST_IDLE;
                bit_cnt  <= '0;
                preload  <= 1'b0;
                miso     <= 1'b0;
                miso_oe  <= 1'b0;
                busy     <= 1'b0;
`ifdef SPI_MEM_TARGET_WREN_EN
                if (saw_write) begin
                    wel <= 1'b0;
                end
                saw_write <= 1'b0;
                status_rd <= 1'b0;
`endif
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (!cs_sync && armed) begin
                            state   <= ST_CMD;
                            bit_cnt <= '0;
                            busy    <= 1'b1;
                        end
                    end

                    ST_CMD: begin
                        if (sclk_rise) begin
                            shift_in <= rx_byte;
                            if (bit_cnt == BYTE_LAST) begin
                                bit_cnt <= '0;
                                case (rx_byte)
                                    CMD_READ: begin
                                        state    <= ST_ADDR;
                                        is_write <= 1'b0;
                                    end
                                    CMD_WRITE: begin
                                        state    <= ST_ADDR;
                                        is_write <= 1'b1;
`ifdef SPI_MEM_TARGET_WREN_EN
                                        saw_write <= 1'b1;
`endif
                                    end
`ifdef SPI_MEM_TARGET_WREN_EN
                                    CMD_WREN: begin
                                        wel   <= 1'b1;
                                        state <= ST_IGNORE;
                                    end
                                    CMD_RDSR: begin
                                        state     <= ST_DATA_RD;
                                        status_rd <= 1'b1;
                                        preload   <= 1'b1;
                                        miso_oe   <= 1'b1;
                                    end
`endif
                                    default: state <= ST_IGNORE;
                                endcase
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end

                    ST_ADDR: begin
                        if (sclk_rise) begin
                            addr <= AW'({addr, mosi_sync});
                            if (bit_cnt == ADDR_LAST) begin
                                bit_cnt <= '0;
                                if (is_write) begin
                                    state <= ST_DATA_WR;
                                end else begin
                                    state   <= ST_DATA_RD;
                                    preload <= 1'b1;
                                    miso_oe <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end

                    ST_DATA_RD: begin
                        if (sclk_fall) begin
                            if (preload) begin
                                miso     <= next_tx[7];
                                tx_shift <= {next_tx[6:0], 1'b0};
                                preload  <= 1'b0;
                            end else begin
                                miso     <= tx_shift[7];
                                tx_shift <= {tx_shift[6:0], 1'b0};
                            end
                        end else if (sclk_rise) begin
                            if (bit_cnt == BYTE_LAST) begin
                                bit_cnt <= '0;
                                addr    <= addr + 1'b1;
                                preload <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end

                    ST_DATA_WR: begin
                        if (sclk_rise) begin
                            shift_in <= rx_byte;
                            if (bit_cnt == BYTE_LAST) begin
                                bit_cnt <= '0;
                                wr_step <= 1'b1;
                                wr_data <= rx_byte;
`ifdef SPI_MEM_TARGET_WREN_EN
                                wr_keep <= wel;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end

                    ST_IGNORE: ;

                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Later assignment wins, so an SPI write beats a host write to the same byte.
    always_ff @(posedge clk) begin
        if (host_we) begin
            mem[host_addr] <= host_wdata;
        end
        if (wr_commit) begin
            mem[addr] <= wr_data;
        end
    end

    assign host_rdata = mem[host_addr];

endmodule

// File: tb/tb_spi_mem_target.sv
// Randomized bench for spi_mem_target: acts as an SPI mode-0 controller and checks against
// a byte-array reference model of the memory.
module tb_spi_mem_target;

    localparam int AB   = 3;
    localparam int MB   = 256;
    localparam int SS   = 2;
    localparam int HALF = 8;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic       sclk       = 1'b0;
    logic       cs_n       = 1'b1;
    logic       mosi       = 1'b0;
    logic       host_we    = 1'b0;
    logic [7:0] host_addr  = '0;
    logic [7:0] host_wdata = '0;
    logic       miso;
    logic       miso_oe;
    logic       busy;
    logic [7:0] host_rdata;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] ref_mem [MB];
    bit         model_wel = 1'b0;

    spi_mem_target #(
        .ADDR_BYTES  (AB),
        .MEM_BYTES   (MB),
        .SYNC_STAGES (SS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sclk       (sclk),
        .cs_n       (cs_n),
        .mosi       (mosi),
        .miso       (miso),
        .miso_oe    (miso_oe),
        .busy       (busy),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic host_write(input int a, input logic [7:0] d);
        host_we    = 1'b1;
        host_addr  = 8'(a);
        host_wdata = d;
        tick(1);
        host_we    = 1'b0;
        ref_mem[a % MB] = d;
    endtask

    task automatic host_check(input int a, input string tag);
        host_addr = 8'(a % MB);
        #1;
        chk(tag, host_rdata, ref_mem[a % MB]);
    endtask

    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx,
                        output logic oe_any, output logic oe_all);
        rx     = '0;
        oe_any = 1'b0;
        oe_all = 1'b1;
        for (int b = 7; b >= 8 - nbits; b--) begin
            mosi = tx[b];
            tick(HALF);
            rx[b]  = miso;
            oe_any = oe_any | miso_oe;
            oe_all = oe_all & miso_oe;
            sclk = 1'b1;
            tick(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic frame_begin();
        cs_n = 1'b0;
        tick(HALF);
    endtask

    task automatic frame_end(input bit exp_busy);
        tick(HALF);
        chk("busy_selected", busy, exp_busy);
        cs_n = 1'b1;
        repeat (SS + 1) @(posedge clk);
        #1;
        chk("busy_deselect", busy, 1'b0);
        tick(2 * HALF);
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input int a, input bit rand_hi);
        logic [7:0] rx, b;
        logic       oa, ol, any;
        xfer(cmd, 8, rx, oa, ol);
        any = oa;
        for (int k = AB - 1; k >= 0; k--) begin
            b = (k == 0) ? 8'(a) : (rand_hi ? 8'($urandom) : 8'h00);
            xfer(b, 8, rx, oa, ol);
            any = any | oa;
        end
        chk("hdr_oe_low", any, 1'b0);
    endtask

    task automatic spi_read(input int a, input int n, input bit rand_hi);
        logic [7:0] rx;
        logic       oa, ol;
        frame_begin();
        send_hdr(8'h03, a, rand_hi);
        for (int i = 0; i < n; i++) begin
            xfer(8'($urandom), 8, rx, oa, ol);
            chk("rd_data", rx, ref_mem[(a + i) % MB]);
            chk("rd_oe", ol, 1'b1);
        end
        frame_end(1'b1);
        chk("rd_oe_after", miso_oe, 1'b0);
    endtask

    task automatic spi_write(input int a, input logic [7:0] data[$], input int partial,
                             input bit rand_hi);
        logic [7:0] rx;
        logic       oa, ol, any;
        bit         commit;
`ifdef SPI_MEM_TARGET_WREN_EN
        commit = model_wel;
`else
        commit = 1'b1;
`endif
        any = 1'b0;
        frame_begin();
        send_hdr(8'h02, a, rand_hi);
        foreach (data[i]) begin
            xfer(data[i], 8, rx, oa, ol);
            any = any | oa;
        end
        if (partial > 0) begin
            xfer(8'($urandom), partial, rx, oa, ol);
            any = any | oa;
        end
        chk("wr_oe_low", any, 1'b0);
        frame_end(1'b1);
        if (commit) begin
            foreach (data[i]) ref_mem[(a + i) % MB] = data[i];
        end
        model_wel = 1'b0;
        for (int i = 0; i <= data.size(); i++) host_check(a + i, "wr_mem");
    endtask

    task automatic spi_unknown(input logic [7:0] cmd);
        logic [7:0] rx;
        logic       oa, ol;
        frame_begin();
        xfer(cmd, 8, rx, oa, ol);
        chk("unk_cmd_oe", oa, 1'b0);
        for (int i = 0; i < 2; i++) begin
            xfer(8'($urandom), 8, rx, oa, ol);
            chk("unk_miso", rx, 8'h00);
            chk("unk_oe", oa, 1'b0);
        end
        frame_end(1'b1);
    endtask

`ifdef SPI_MEM_TARGET_WREN_EN
    task automatic spi_wren();
        logic [7:0] rx;
        logic       oa, ol;
        frame_begin();
        xfer(8'h06, 8, rx, oa, ol);
        frame_end(1'b1);
        model_wel = 1'b1;
    endtask

    task automatic spi_rdsr();
        logic [7:0] rx;
        logic       oa, ol;
        frame_begin();
        xfer(8'h05, 8, rx, oa, ol);
        chk("rdsr_cmd_oe", oa, 1'b0);
        for (int i = 0; i < 2; i++) begin
            xfer(8'($urandom), 8, rx, oa, ol);
            chk("rdsr_val", rx, {6'b0, model_wel, 1'b0});
            chk("rdsr_oe", ol, 1'b1);
        end
        frame_end(1'b1);
    endtask
`endif

    task automatic enable_write();
`ifdef SPI_MEM_TARGET_WREN_EN
        spi_wren();
`endif
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] rx;
        logic [7:0] c;
        logic       oa, ol, any;
        int         op, a, n;

        rst = 1'b1;
        tick(3);
        chk("rst_miso", miso, 1'b0);
        chk("rst_oe", miso_oe, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        tick(4);

        for (int i = 0; i < MB; i++) host_write(i, 8'($urandom));

        host_write(8'h10, 8'h11);
        host_write(8'h11, 8'h22);
        host_write(8'h12, 8'h33);
        host_write(8'h13, 8'h44);
        spi_read(8'h10, 4, 1'b0);

        enable_write();
        q = {8'hAA, 8'hBB, 8'hCC};
        spi_write(8'hFE, q, 0, 1'b0);
        host_addr = 8'h00;
        #1;
        chk("wrap_mem00", host_rdata, 8'hCC);
        spi_read(8'hFE, 3, 1'b0);

        enable_write();
        q = {8'h5A};
        spi_write(8'h20, q, 4, 1'b0);
        host_addr = 8'h20;
        #1;
        chk("partial_mem20", host_rdata, 8'h5A);

        spi_unknown(8'h9F);

        frame_begin();
        xfer(8'h03, 8, rx, oa, ol);
        xfer(8'h00, 8, rx, oa, ol);
        xfer(8'h00, 4, rx, oa, ol);
        chk("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        model_wel = 1'b0;
        #1;
        chk("midaddr_rst_miso", miso, 1'b0);
        chk("midaddr_rst_oe", miso_oe, 1'b0);
        chk("midaddr_rst_busy", busy, 1'b0);
        tick(2);
        rst = 1'b0;
        any = 1'b0;
        xfer(8'h01, 4, rx, oa, ol);
        any = any | oa;
        for (int i = 0; i < 3; i++) begin
            xfer(8'($urandom), 8, rx, oa, ol);
            any = any | oa;
            chk("post_rst_miso", rx, 8'h00);
        end
        chk("post_rst_oe", any, 1'b0);
        frame_end(1'b0);
        spi_read(8'h10, 4, 1'b0);

        frame_begin();
        send_hdr(8'h03, 8'h40, 1'b0);
        xfer(8'h00, 8, rx, oa, ol);
        chk("pre_rst_rd", rx, ref_mem[8'h40]);
        xfer(8'h00, 3, rx, oa, ol);
        chk("pre_rst_oe", miso_oe, 1'b1);
        rst = 1'b1;
        model_wel = 1'b0;
        #1;
        chk("middata_rst_miso", miso, 1'b0);
        chk("middata_rst_oe", miso_oe, 1'b0);
        chk("middata_rst_busy", busy, 1'b0);
        tick(2);
        rst = 1'b0;
        xfer(8'h00, 5, rx, oa, ol);
        xfer(8'h00, 8, rx, oa, ol);
        chk("middata_post_oe", oa, 1'b0);
        frame_end(1'b0);

`ifdef SPI_MEM_TARGET_WREN_EN
        host_write(8'h30, 8'h11);
        q = {8'h55};
        spi_write(8'h30, q, 0, 1'b0);
        host_addr = 8'h30;
        #1;
        chk("nowren_mem30", host_rdata, 8'h11);
        spi_wren();
        spi_rdsr();
        spi_write(8'h30, q, 0, 1'b0);
        host_addr = 8'h30;
        #1;
        chk("wren_mem30", host_rdata, 8'h55);
        spi_rdsr();
`endif

        for (int it = 0; it < 30; it++) begin
            op = $urandom_range(0, 4);
            a  = $urandom_range(0, MB - 1);
            n  = $urandom_range(1, 4);
            case (op)
                0: begin
                    host_write(a, 8'($urandom));
                    host_check(a, "rnd_host");
                end
                1, 2: begin
                    if ($urandom_range(0, 3) != 0) enable_write();
                    q = {};
                    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
                    spi_write(a, q, ($urandom_range(0, 1) == 1) ? $urandom_range(1, 7) : 0, 1'b1);
                end
                3: spi_read(a, n, 1'b1);
                default: begin
                    c = 8'($urandom);
`ifdef SPI_MEM_TARGET_WREN_EN
                    if (c == 8'h02 || c == 8'h03 || c == 8'h05 || c == 8'h06) c = 8'h9F;
`else
                    if (c == 8'h02 || c == 8'h03) c = 8'h9F;
`endif
                    spi_unknown(c);
                end
            endcase
        end

        for (int i = 0; i < MB; i++) host_check(i, "final_mem");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
